// File: rtl/kp_pkg.sv
// Shared types and constants for the hex keypad scanner.
package kp_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } kp_state_e;

    // Column 0 strobed (active-low) coming out of reset
    localparam logic [3:0] COLS_RESET = 4'b1110;

    // Key map indexed [row][col]; each 16-bit row holds col3..col0, left to right.
    // r0: 1 2 3 A | r1: 4 5 6 B | r2: 7 8 9 C | r3: 0 F E D
    localparam logic [3:0][3:0][3:0] KEY_MAP = 64'hDEF0_C987_B654_A321;

    function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
        return KEY_MAP[row][col];
    endfunction

    // Index of the active-low strobe in a one-hot column pattern
    function automatic logic [1:0] col_index(input logic [3:0] cols);
        case (cols)
            4'b1110: return 2'd0;
            4'b1101: return 2'd1;
            4'b1011: return 2'd2;
            4'b0111: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/kp_scan_tick.sv
// Free-running column window timer: one tick every SCAN_DIV clocks.
module kp_scan_tick #(
    parameter int SCAN_DIV = 100000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Count 0..SCAN_DIV-1 and wrap
    always_comb begin
        count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tick = (count_q == LAST);

endmodule

// File: rtl/hex_keypad_scanner.sv
// 4x4 hex keypad scanner: column strobing, debounce FSM, key decode and entry shift register.
module hex_keypad_scanner
    import kp_pkg::*;
#(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  rows,
    input  logic        clear,
    output logic [3:0]  cols,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic        key_held,
    output logic [15:0] entry
);

    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_SCANS);

    logic            tick;
    logic [3:0]      rows_meta_q, rows_sync_q;
    kp_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [1:0]      row_idx_q, row_idx_d;
    logic [3:0]      cols_q, cols_d, cols_rot;
    logic [3:0]      key_code_q, key_code_d;
    logic            key_valid_q, key_valid_d;
    logic            key_held_q, key_held_d;
    logic [15:0]     entry_q, entry_d;
    logic [3:0]      row_low;
    logic            is_none, is_single, accept;
    logic [1:0]      sample_row;

    kp_scan_tick #(.SCAN_DIV(SCAN_DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    // Two-flop synchronizer for the asynchronous row returns; idle rows read all-high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rows_meta_q <= 4'hF;
            rows_sync_q <= 4'hF;
        end else begin
            rows_meta_q <= rows;
            rows_sync_q <= rows_meta_q;
        end
    end

    // Classify the synchronized row sample as NONE, SINGLE or MULTI and find the low row
    always_comb begin
        row_low    = ~rows_sync_q;
        is_none    = (row_low == 4'h0);
        is_single  = $onehot(row_low);
        sample_row = 2'd0;
        case (row_low)
            4'b0001: sample_row = 2'd0;
            4'b0010: sample_row = 2'd1;
            4'b0100: sample_row = 2'd2;
            4'b1000: sample_row = 2'd3;
            default: sample_row = 2'd0;
        endcase
    end

    // Scan/debounce/hold FSM; everything advances only on the window tick
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        row_idx_d   = row_idx_q;
        cols_d      = cols_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;
        accept      = 1'b0;
        cnt_inc     = cnt_q + 1'b1;
        cols_rot    = {cols_q[2:0], cols_q[3]};
        if (tick) begin
            case (state_q)
                SCAN: begin
                    if (is_single) begin
                        row_idx_d = sample_row;
                        if (DEBOUNCE_SCANS == 1) begin
                            accept = 1'b1;
                        end else begin
                            cnt_d   = CNT_W'(1);
                            state_d = DEBOUNCE;
                        end
                    end else begin
                        cols_d = cols_rot;
                    end
                end
                DEBOUNCE: begin
                    if (is_single && (sample_row == row_idx_q)) begin
                        if (cnt_inc == CNT_LAST) begin
                            accept = 1'b1;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        cnt_d   = '0;
                        cols_d  = cols_rot;
                        state_d = SCAN;
                    end
                end
                HELD: begin
                    if (is_none) begin
                        if (cnt_inc == CNT_LAST) begin
                            key_held_d = 1'b0;
                            cnt_d      = '0;
                            cols_d     = cols_rot;
                            state_d    = SCAN;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        cnt_d = '0;
                    end
                end
                default: begin
                    state_d = SCAN;
                    cnt_d   = '0;
                    cols_d  = COLS_RESET;
                end
            endcase
        end
        if (accept) begin
            key_code_d  = key_lookup(sample_row, col_index(cols_q));
            key_valid_d = 1'b1;
            key_held_d  = 1'b1;
            cnt_d       = '0;
            state_d     = HELD;
        end
    end

    // Entry word: clear beats a simultaneous accepted nibble
    always_comb begin
        entry_d = entry_q;
        if (clear) begin
            entry_d = 16'h0000;
        end else if (key_valid_q) begin
            entry_d = {entry_q[11:0], key_code_q};
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SCAN;
            cnt_q       <= '0;
            row_idx_q   <= 2'd0;
            cols_q      <= COLS_RESET;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
            entry_q     <= 16'h0000;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            row_idx_q   <= row_idx_d;
            cols_q      <= cols_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
            entry_q     <= entry_d;
        end
    end

    assign cols      = cols_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;
    assign entry     = entry_q;

endmodule
